// File: rtl/ring_out_arb.sv
// Ring output arbiter: merges pass-through ring traffic with local F2C responses and
// C2F requests onto the ring-out stage, using a one-entry skid and starvation relief.
module ring_out_arb #(
    parameter int STARVE_MAX = 8
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [7:0]  CoreID,
    input  logic        RingReqInValidQ501H,
    input  logic [9:0]  RingReqInRequestorQ501H,
    input  logic [1:0]  RingReqInOpcodeQ501H,
    input  logic [31:0] RingReqInAddressQ501H,
    input  logic [31:0] RingReqInDataQ501H,
    input  logic        F2C_RspValidQ501H,
    input  logic [9:0]  F2C_RspRequestorQ501H,
    input  logic [1:0]  F2C_RspOpcodeQ501H,
    input  logic [31:0] F2C_RspAddressQ501H,
    input  logic [31:0] F2C_RspDataQ501H,
    input  logic        C2F_ReqValidQ501H,
    input  logic [9:0]  C2F_ReqRequestorQ501H,
    input  logic [1:0]  C2F_ReqOpcodeQ501H,
    input  logic [31:0] C2F_ReqAddressQ501H,
    input  logic [31:0] C2F_ReqDataQ501H,
    output logic [1:0]  SelRingRspOutQ501H,
    output logic        RingReqOutValidQ502H,
    output logic [9:0]  RingReqOutRequestorQ502H,
    output logic [1:0]  RingReqOutOpcodeQ502H,
    output logic [31:0] RingReqOutAddressQ502H,
    output logic [31:0] RingReqOutDataQ502H,
    output logic        SkidFullQnnnH
);

    localparam logic [1:0] OP_RD       = 2'd0;
    localparam logic [1:0] OP_WR       = 2'd1;
    localparam logic [1:0] OP_RD_RSP   = 2'd2;
    localparam logic [1:0] OP_WR_BCAST = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_PASS = 2'd1;
    localparam logic [1:0] SEL_F2C  = 2'd2;
    localparam logic [1:0] SEL_C2F  = 2'd3;

    localparam int         PW         = 76;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [PW-1:0] ringPay, f2cPay, c2fPay;
    logic [PW-1:0] skidPayReg, skidPayNext;
    logic [PW-1:0] outPayReg, outPayNext;
    logic          skidValidReg, skidValidNext;
    logic          outValidReg;
    logic [3:0]    starveCntReg, starveCntNext;
    logic          rrReg, rrNext;
    logic          passThru, anyLocal, localGrant, toLocal, fromSkid;
    logic [1:0]    localSel, sel;

    assign ringPay = {RingReqInRequestorQ501H, RingReqInOpcodeQ501H,
                      RingReqInAddressQ501H, RingReqInDataQ501H};
    assign f2cPay  = {F2C_RspRequestorQ501H, F2C_RspOpcodeQ501H,
                      F2C_RspAddressQ501H, F2C_RspDataQ501H};
    assign c2fPay  = {C2F_ReqRequestorQ501H, C2F_ReqOpcodeQ501H,
                      C2F_ReqAddressQ501H, C2F_ReqDataQ501H};

    // Anything addressed to, or returning to, this core leaves the ring here.
    always_comb begin
        toLocal = 1'b0;
        if ((RingReqInOpcodeQ501H == OP_RD || RingReqInOpcodeQ501H == OP_WR) &&
            RingReqInAddressQ501H[31:24] == CoreID)
            toLocal = 1'b1;
        if ((RingReqInOpcodeQ501H == OP_RD_RSP || RingReqInOpcodeQ501H == OP_WR_BCAST) &&
            RingReqInRequestorQ501H[9:2] == CoreID)
            toLocal = 1'b1;
        passThru = RingReqInValidQ501H && !toLocal;
    end

    assign anyLocal = F2C_RspValidQ501H || C2F_ReqValidQ501H;

    always_comb begin
        localSel = SEL_NONE;
        if (F2C_RspValidQ501H && C2F_ReqValidQ501H)
            localSel = rrReg ? SEL_C2F : SEL_F2C;
        else if (F2C_RspValidQ501H)
            localSel = SEL_F2C;
        else if (C2F_ReqValidQ501H)
            localSel = SEL_C2F;
    end

    always_comb begin
        sel           = SEL_NONE;
        fromSkid      = 1'b0;
        skidValidNext = skidValidReg;
        skidPayNext   = skidPayReg;
        if (skidValidReg) begin
            // Skid drains first; a new pass-through immediately refills it.
            sel           = SEL_PASS;
            fromSkid      = 1'b1;
            skidValidNext = passThru;
            if (passThru)
                skidPayNext = ringPay;
        end else if (passThru && starveCntReg == STARVE_LIM && anyLocal) begin
            sel           = localSel;
            skidValidNext = 1'b1;
            skidPayNext   = ringPay;
        end else if (passThru) begin
            sel = SEL_PASS;
        end else if (anyLocal) begin
            sel = localSel;
        end
    end

    assign localGrant = (sel == SEL_F2C) || (sel == SEL_C2F);

    always_comb begin
        starveCntNext = starveCntReg;
        rrNext        = rrReg;
        if (localGrant) begin
            starveCntNext = 4'd0;
            rrNext        = (sel == SEL_F2C);
        end else if (anyLocal && starveCntReg != STARVE_LIM) begin
            starveCntNext = starveCntReg + 4'd1;
        end
    end

    always_comb begin
        outPayNext = '0;
        case (sel)
            SEL_PASS: outPayNext = fromSkid ? skidPayReg : ringPay;
            SEL_F2C:  outPayNext = f2cPay;
            SEL_C2F:  outPayNext = c2fPay;
            default:  outPayNext = '0;
        endcase
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            outValidReg  <= 1'b0;
            outPayReg    <= '0;
            skidValidReg <= 1'b0;
            skidPayReg   <= '0;
            starveCntReg <= 4'd0;
            rrReg        <= 1'b0;
        end else begin
            outValidReg  <= (sel != SEL_NONE);
            outPayReg    <= outPayNext;
            skidValidReg <= skidValidNext;
            skidPayReg   <= skidPayNext;
            starveCntReg <= starveCntNext;
            rrReg        <= rrNext;
        end
    end

    assign SelRingRspOutQ501H   = sel;
    assign RingReqOutValidQ502H = outValidReg;
    assign {RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
            RingReqOutAddressQ502H, RingReqOutDataQ502H} = outPayReg;
    assign SkidFullQnnnH        = skidValidReg;

endmodule

// File: doc/ring_out_arb.md
RING_OUT_ARB -- requirements
Module: ring_out_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive unserved local-valid cycles that forces an injection (legal range 1..15).
REQ-002 SHALL have ports `QClk` (in, 1): the only clock; `RstQnnnH` (in, 1): asynchronous, active-high reset.
REQ-003 SHALL have port `CoreID` (in, 8): the local core id.
REQ-004 SHALL have ring-in ports (in), all Q501H: `RingReqInValidQ501H` (1), `RingReqInRequestorQ501H` (10), `RingReqInOpcodeQ501H` (t_opcode), `RingReqInAddressQ501H` (32), `RingReqInDataQ501H` (32).
REQ-005 SHALL have F2C response ports (in), all Q501H: `F2C_RspValidQ501H`, `F2C_RspRequestorQ501H`, `F2C_RspOpcodeQ501H`, `F2C_RspAddressQ501H`, `F2C_RspDataQ501H`, with the same widths as REQ-004.
REQ-006 SHALL have C2F request ports (in), all Q501H: `C2F_ReqValidQ501H`, `C2F_ReqRequestorQ501H`, `C2F_ReqOpcodeQ501H`, `C2F_ReqAddressQ501H`, `C2F_ReqDataQ501H`, with the same widths as REQ-004.
REQ-007 SHALL have port `SelRingRspOutQ501H` (out, 2): the combinational winner code. 00 = NONE, 01 = PASS (ring or skid), 10 = F2C_RSP, 11 = C2F_REQ.
REQ-008 SHALL have ring-out ports (out, registered), all Q502H: `RingReqOutValidQ502H`, `RingReqOutRequestorQ502H`, `RingReqOutOpcodeQ502H`, `RingReqOutAddressQ502H`, `RingReqOutDataQ502H`.
REQ-009 SHALL have port `SkidFullQnnnH` (out, 1): the skid entry is occupied.

Function
REQ-010 SHALL classify a ring-in transaction as pass-through when it is valid and is none of the following:
- (opcode is RD or WR) AND Address[31:24] == CoreID;
- opcode is RD_RSP AND Requestor[9:2] == CoreID;
- opcode is WR_BCAST AND Requestor[9:2] == CoreID.
REQ-011 SHALL treat a WR_BCAST from another core as pass-through; local consumption is handled elsewhere.
REQ-012 SHALL drop non-pass-through ring-in slots, leaving a bubble.
REQ-013 SHALL keep a one-entry skid buffer (valid plus payload) that holds a displaced pass-through transaction.
REQ-014 SHALL keep a 4-bit saturating starvation counter:
- increments when (F2C or C2F valid) and the winner is neither F2C_RSP nor C2F_REQ;
- clears on any local grant;
- saturates at STARVE_MAX.
REQ-015 SHALL keep a 1-bit round-robin pointer, RR (0 prefers F2C, 1 prefers C2F), which toggles to the other source after any local grant.
REQ-016 SHALL pick the winner in this priority order:
1. If the skid is full, PASS from skid. An incoming pass-through is written into the skid in the same cycle, so the skid stays full; otherwise the skid empties.
2. If the skid is empty, there is a pass-through, the counter equals STARVE_MAX, and a local source is valid: the local source wins and the pass-through is captured into the skid.
3. If the skid is empty and there is a pass-through, PASS from ring.
4. If any local source is valid: the local winner is chosen by RR when both are valid, otherwise the valid one.
5. Otherwise NONE.
REQ-017 SHALL register the selected payload into the Q502H outputs every cycle, with RingReqOutValidQ502H = (winner != NONE); payload is don't-care when valid = 0.
REQ-018 SHALL give a latency of exactly 1 cycle from a Q501H grant to Q502H ring-out.
REQ-019 SHALL never lose a pass-through transaction and never reorder two pass-through transactions.
REQ-020 SHALL assert at most one output transaction per cycle.
REQ-021 SHALL treat SelRingRspOutQ501H == F2C_RSP as the F2C dequeue acknowledge, and SelRingRspOutQ501H == C2F_REQ as the C2F acknowledge; sources hold their request until acknowledged.
REQ-022 SHALL ignore all local inputs when their valid is low.

Reset
REQ-023 SHALL, while RstQnnnH = 1 (asynchronous), force RingReqOutValidQ502H = 0, skid valid = 0, counter = 0, RR = 0 and all payload registers = 0.
REQ-024 SHALL, when reset asserts mid-operation, discard the skid content and any in-flight output.
REQ-025 SHALL, on the first cycle after reset, have SelRingRspOutQ501H reflect only the inputs present in that cycle.

Verification
REQ-026 Bench SHALL cover pass-through priority: CoreID = 0x02; ring RD to Address 0x0500_0010 with F2C valid on the same cycle -> winner PASS; the next cycle shows the ring RD on ring-out; the counter reads 1.
REQ-027 Bench SHALL cover local consume: ring WR to Address 0x0210_0000 with CoreID = 0x02 and C2F valid -> winner C2F_REQ; ring-out carries the C2F payload; RR = 0.
REQ-028 Bench SHALL cover starvation: continuous pass-through for 8 cycles with F2C valid and STARVE_MAX = 8 -> on cycle 9 F2C wins, the pass-through is captured into the skid, and SkidFullQnnnH = 1. The skid drains on the next pass-through-free cycle with order preserved.
REQ-029 Bench SHALL cover round-robin: F2C and C2F both valid for 4 empty ring cycles -> winners F2C, C2F, F2C, C2F.
REQ-030 Bench SHALL cover broadcast return: ring WR_BCAST with Requestor[9:2] = CoreID -> dropped; winner NONE when no local source is valid.
REQ-031 Bench SHALL cover reset mid-operation: assert RstQnnnH while the skid is full -> SkidFullQnnnH and RingReqOutValidQ502H drop to 0 immediately, without waiting for a clock edge.
